// File: rtl/avr_seq_pkg.sv
// Shared types for the AVR-subset execution sequencer: ALU op codes, FSM states,
// opcode match/mask constants and the decoded-instruction record.
package avr_seq_pkg;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_ADC = 5'd1,
    ALU_SUB = 5'd2,
    ALU_AND = 5'd3,
    ALU_OR  = 5'd4,
    ALU_EOR = 5'd5,
    ALU_MOV = 5'd6,
    ALU_CP  = 5'd7,
    ALU_LDI = 5'd8,
    ALU_NOP = 5'd31
  } aluop_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALT
  } state_e;

  // Two-register ops are identified by instr[15:10]
  localparam logic [5:0] OP6_ADD = 6'b000011;
  localparam logic [5:0] OP6_ADC = 6'b000111;
  localparam logic [5:0] OP6_SUB = 6'b000110;
  localparam logic [5:0] OP6_CP  = 6'b000101;
  localparam logic [5:0] OP6_AND = 6'b001000;
  localparam logic [5:0] OP6_EOR = 6'b001001;
  localparam logic [5:0] OP6_OR  = 6'b001010;
  localparam logic [5:0] OP6_MOV = 6'b001011;

  localparam logic [15:0] OPC_IMM_MASK = 16'hF000;
  localparam logic [15:0] OPC_LDI      = 16'hE000;
  localparam logic [15:0] OPC_SUBI     = 16'h5000;
  localparam logic [15:0] OPC_RJMP     = 16'hC000;
  localparam logic [15:0] OPC_BR_MASK  = 16'hFC07;
  localparam logic [15:0] OPC_BREQ     = 16'hF001;
  localparam logic [15:0] OPC_BRNE     = 16'hF401;
  localparam logic [15:0] OPC_NOP      = 16'h0000;
  localparam logic [15:0] OPC_BREAK    = 16'h9598;

  typedef struct packed {
    aluop_e      aluop;
    logic [4:0]  rd;
    logic [4:0]  rr;
    logic [7:0]  imm;
    logic        imm_sel;
    logic        we;
    logic        flag_upd;
    logic        is_rjmp;
    logic        is_breq;
    logic        is_brne;
    logic        is_break;
    logic        illegal;
    logic [11:0] offset;
  } dec_t;

  function automatic logic [11:0] sext7(input logic [6:0] k);
    return {{5{k[6]}}, k};
  endfunction

endpackage

// File: rtl/avr_exec_sequencer_if.sv
// Program-memory fetch handshake between the sequencer (master) and instruction memory (slave).
interface avr_exec_sequencer_if #(parameter int PC_W = 8);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/avr_decode.sv
// Combinational decoder: 16-bit AVR-subset instruction word to control fields.
module avr_decode
  import avr_seq_pkg::*;
(
  input  logic [15:0] instr_i,
  output dec_t        dec_o
);

  logic [4:0] d5;
  logic [4:0] r5;

  assign d5 = {instr_i[8], instr_i[7:4]};
  assign r5 = {instr_i[9], instr_i[3:0]};

  always_comb begin
    dec_o       = '0;
    dec_o.aluop = ALU_NOP;
    if (instr_i == OPC_NOP) begin
      dec_o.aluop = ALU_NOP;
    end else if (instr_i == OPC_BREAK) begin
      dec_o.is_break = 1'b1;
    end else if ((instr_i & OPC_BR_MASK) == OPC_BREQ) begin
      dec_o.is_breq = 1'b1;
      dec_o.offset  = sext7(instr_i[9:3]);
    end else if ((instr_i & OPC_BR_MASK) == OPC_BRNE) begin
      dec_o.is_brne = 1'b1;
      dec_o.offset  = sext7(instr_i[9:3]);
    end else if ((instr_i & OPC_IMM_MASK) == OPC_RJMP) begin
      dec_o.is_rjmp = 1'b1;
      dec_o.offset  = instr_i[11:0];
    end else if ((instr_i & OPC_IMM_MASK) == OPC_LDI ||
                 (instr_i & OPC_IMM_MASK) == OPC_SUBI) begin
      // Immediate forms only reach the upper register bank R16..R31
      dec_o.rd      = {1'b1, instr_i[7:4]};
      dec_o.imm     = {instr_i[11:8], instr_i[3:0]};
      dec_o.imm_sel = 1'b1;
      dec_o.we      = 1'b1;
      if ((instr_i & OPC_IMM_MASK) == OPC_LDI) begin
        dec_o.aluop = ALU_LDI;
      end else begin
        dec_o.aluop    = ALU_SUB;
        dec_o.flag_upd = 1'b1;
      end
    end else begin
      dec_o.rd = d5;
      dec_o.rr = r5;
      case (instr_i[15:10])
        OP6_ADD: begin dec_o.aluop = ALU_ADD; dec_o.we = 1'b1; dec_o.flag_upd = 1'b1; end
        OP6_ADC: begin dec_o.aluop = ALU_ADC; dec_o.we = 1'b1; dec_o.flag_upd = 1'b1; end
        OP6_SUB: begin dec_o.aluop = ALU_SUB; dec_o.we = 1'b1; dec_o.flag_upd = 1'b1; end
        OP6_CP:  begin dec_o.aluop = ALU_CP;                   dec_o.flag_upd = 1'b1; end
        OP6_AND: begin dec_o.aluop = ALU_AND; dec_o.we = 1'b1; dec_o.flag_upd = 1'b1; end
        OP6_EOR: begin dec_o.aluop = ALU_EOR; dec_o.we = 1'b1; dec_o.flag_upd = 1'b1; end
        OP6_OR:  begin dec_o.aluop = ALU_OR;  dec_o.we = 1'b1; dec_o.flag_upd = 1'b1; end
        OP6_MOV: begin dec_o.aluop = ALU_MOV; dec_o.we = 1'b1; end
        default: begin
          dec_o.rd      = '0;
          dec_o.rr      = '0;
          dec_o.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/avr_exec_sequencer.sv
// FETCH/DECODE/EXECUTE sequencer owning PC and C/Z flags for the AVR-subset ALU core.
// Optional single-step mode: define AVR_SEQ_STEP_EN to add the step input.
module avr_exec_sequencer
  import avr_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int RST_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef AVR_SEQ_STEP_EN
  input  logic            step,
`endif
  avr_exec_sequencer_if.master imem,
  output logic [4:0]      aluop,
  output logic [4:0]      rf_rd_addr,
  output logic [4:0]      rf_rr_addr,
  output logic [7:0]      imm,
  output logic            imm_sel,
  output logic            rf_we,
  input  logic            alu_cy,
  input  logic            alu_zy,
  output logic            flag_c,
  output logic            flag_z,
  output logic [PC_W-1:0] pc,
  output logic            halt,
  output logic            illegal
);

  state_e          state_q;
  logic [15:0]     ir_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, rf_we_q, illegal_q, halt_q;
  logic            flag_c_q, flag_z_q;
  logic            go;
  logic            take;
  logic [31:0]     off32;
  dec_t            dec;

  avr_decode u_decode (
    .instr_i (ir_q),
    .dec_o   (dec)
  );

`ifdef AVR_SEQ_STEP_EN
  assign go = start | step;
`else
  assign go = start;
`endif

  // Branch condition sees the flags as they stood before this EXECUTE updates them
  assign take  = dec.is_rjmp | (dec.is_breq & flag_z_q) | (dec.is_brne & ~flag_z_q);
  assign off32 = {{20{dec.offset[11]}}, dec.offset};
  assign pc_d  = pc_q + PC_W'(1) + (take ? off32[PC_W-1:0] : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ir_q      <= OPC_NOP;
      pc_q      <= PC_W'(RST_PC);
      req_q     <= 1'b0;
      rf_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      halt_q    <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (req_q && imem.imem_ack) begin
            ir_q    <= imem.imem_rdata;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          rf_we_q   <= dec.we;
          illegal_q <= dec.illegal;
          state_q   <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (dec.flag_upd) begin
            flag_c_q <= alu_cy;
            flag_z_q <= alu_zy;
          end
          pc_q <= pc_d;
          if (dec.is_break) begin
            state_q <= S_HALT;
            halt_q  <= 1'b1;
          end else begin
`ifdef AVR_SEQ_STEP_EN
            state_q <= S_IDLE;
`else
            state_q <= S_FETCH;
            req_q   <= 1'b1;
`endif
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign aluop          = dec.aluop;
  assign rf_rd_addr     = dec.rd;
  assign rf_rr_addr     = dec.rr;
  assign imm            = dec.imm;
  assign imm_sel        = dec.imm_sel;
  assign rf_we          = rf_we_q;
  assign flag_c         = flag_c_q;
  assign flag_z         = flag_z_q;
  assign pc             = pc_q;
  assign halt           = halt_q;
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_avr_exec_sequencer.sv
// Directed bench for avr_exec_sequencer: fetch handshake, decode, flags, PC flow, halt and reset.
module tb_avr_exec_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       alu_cy;
  logic       alu_zy;
  logic [4:0] aluop;
  logic [4:0] rf_rd_addr;
  logic [4:0] rf_rr_addr;
  logic [7:0] imm;
  logic       imm_sel;
  logic       rf_we;
  logic       flag_c;
  logic       flag_z;
  logic [7:0] pc;
  logic       halt;
  logic       illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  avr_exec_sequencer_if #(.PC_W(8)) imem_bus ();

  avr_exec_sequencer #(.PC_W(8), .RST_PC(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem       (imem_bus),
    .aluop      (aluop),
    .rf_rd_addr (rf_rd_addr),
    .rf_rr_addr (rf_rr_addr),
    .imm        (imm),
    .imm_sel    (imm_sel),
    .rf_we      (rf_we),
    .alu_cy     (alu_cy),
    .alu_zy     (alu_zy),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .pc         (pc),
    .halt       (halt),
    .illegal    (illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a fetch request, optionally withholds ack, then returns the word.
  task automatic serve(input logic [15:0] instr, input int hold, output bit to);
    to = 1'b0;
    for (int i = 0; i < 20 && imem_bus.imem_req !== 1'b1; i++) tick();
    if (imem_bus.imem_req !== 1'b1) begin
      to = 1'b1;
    end else begin
      repeat (hold) tick();
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = instr;
      tick();
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 16'h0000;
    end
  endtask

  task automatic test_reset();
    tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL rst_pc: got %0h want 0", pc); end
    tests_run++; if (imem_bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %b want 0", imem_bus.imem_req); end
    tests_run++; if (aluop !== 5'd31) begin tests_failed++; $display("FAIL rst_aluop: got %0d want 31", aluop); end
    tests_run++; if ({halt, flag_c, flag_z, rf_we, illegal} !== 5'b0) begin tests_failed++; $display("FAIL rst_outs: got %b want 00000", {halt, flag_c, flag_z, rf_we, illegal}); end
    tick();
    tests_run++; if (imem_bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL idle_wait: req got %b want 0", imem_bus.imem_req); end
  endtask

  task automatic test_ldi();
    bit to;
    start = 1'b1; tick(); start = 1'b0;
    tests_run++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 8'h00) begin tests_failed++; $display("FAIL ldi_fetch: req/addr got %b/%0h want 1/0", imem_bus.imem_req, imem_bus.imem_addr); end
    serve(16'hE005, 0, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL ldi_timeout: got %b want 0", to); end
    tests_run++; if ({aluop, rf_rd_addr, imm, imm_sel} !== {5'd8, 5'd16, 8'h05, 1'b1}) begin tests_failed++; $display("FAIL ldi_decode: got op%0d rd%0d imm%0h sel%b want op8 rd16 imm5 sel1", aluop, rf_rd_addr, imm, imm_sel); end
    tick();
    tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("FAIL ldi_we: got %b want 1", rf_we); end
    tests_run++; if (aluop !== 5'd8 || imm !== 8'h05) begin tests_failed++; $display("FAIL ldi_hold: got op%0d imm%0h want op8 imm5", aluop, imm); end
    tick();
    tests_run++; if (pc !== 8'h01 || rf_we !== 1'b0) begin tests_failed++; $display("FAIL ldi_pc: got pc%0h we%b want pc1 we0", pc, rf_we); end
  endtask

  task automatic test_add();
    bit to;
    alu_cy = 1'b1; alu_zy = 1'b0;
    serve(16'h0F01, 0, to);
    tests_run++; if ({aluop, rf_rd_addr, rf_rr_addr, imm_sel} !== {5'd0, 5'd16, 5'd17, 1'b0}) begin tests_failed++; $display("FAIL add_decode: got op%0d rd%0d rr%0d sel%b want op0 rd16 rr17 sel0", aluop, rf_rd_addr, rf_rr_addr, imm_sel); end
    tick();
    tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("FAIL add_we: got %b want 1", rf_we); end
    tick();
    tests_run++; if ({flag_c, flag_z} !== 2'b10 || pc !== 8'h02) begin tests_failed++; $display("FAIL add_flags: got c%b z%b pc%0h want c1 z0 pc2", flag_c, flag_z, pc); end
  endtask

  task automatic test_cp_branch();
    bit to;
    serve(16'h0000, 0, to); tick(); tick();
    serve(16'h0000, 0, to); tick(); tick();
    tests_run++; if (pc !== 8'h04) begin tests_failed++; $display("FAIL nop_pc: got %0h want 4", pc); end
    alu_cy = 1'b0; alu_zy = 1'b1;
    serve(16'h1701, 0, to);
    tests_run++; if (aluop !== 5'd7) begin tests_failed++; $display("FAIL cp_decode: got %0d want 7", aluop); end
    tick();
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL cp_we: got %b want 0", rf_we); end
    tick();
    tests_run++; if ({flag_c, flag_z} !== 2'b01 || pc !== 8'h05) begin tests_failed++; $display("FAIL cp_flags: got c%b z%b pc%0h want c0 z1 pc5", flag_c, flag_z, pc); end
    alu_cy = 1'b1; alu_zy = 1'b0;
    serve(16'hF019, 0, to); tick();
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL breq_we: got %b want 0", rf_we); end
    tick();
    tests_run++; if (pc !== 8'h09) begin tests_failed++; $display("FAIL breq_taken: got pc %0h want 9", pc); end
    tests_run++; if ({flag_c, flag_z} !== 2'b01) begin tests_failed++; $display("FAIL breq_flags: got c%b z%b want c0 z1", flag_c, flag_z); end
    serve(16'hF419, 0, to); tick(); tick();
    tests_run++; if (pc !== 8'h0A) begin tests_failed++; $display("FAIL brne_not_taken: got pc %0h want a", pc); end
  endtask

  task automatic test_rjmp();
    bit to;
    for (int n = 0; n < 2; n++) begin
      serve(16'hCFFF, 0, to); tick();
      tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL rjmp_we%0d: got %b want 0", n, rf_we); end
      tick();
      tests_run++; if (pc !== 8'h0A || imem_bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL rjmp_pc%0d: got pc%0h req%b want pca req1", n, pc, imem_bus.imem_req); end
    end
  endtask

  task automatic test_ack_wait();
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 8'h0A) begin tests_failed++; $display("FAIL wait_req%0d: got req%b addr%0h want req1 addra", i, imem_bus.imem_req, imem_bus.imem_addr); end
      tick();
    end
    tests_run++; if (imem_bus.imem_req !== 1'b1 || rf_we !== 1'b0) begin tests_failed++; $display("FAIL wait_hold: got req%b we%b want req1 we0", imem_bus.imem_req, rf_we); end
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 16'h0000;
    tick();
    imem_bus.imem_ack = 1'b0;
    tick();
    tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("FAIL wait_nop_illegal: got %b want 0", illegal); end
    tick();
    tests_run++; if (pc !== 8'h0B) begin tests_failed++; $display("FAIL wait_nop_pc: got %0h want b", pc); end
  endtask

  task automatic test_illegal_imm();
    bit to;
    serve(16'hFFFF, 0, to); tick();
    tests_run++; if (illegal !== 1'b1 || rf_we !== 1'b0) begin tests_failed++; $display("FAIL illegal_pulse: got ill%b we%b want ill1 we0", illegal, rf_we); end
    tick();
    tests_run++; if (illegal !== 1'b0 || pc !== 8'h0C) begin tests_failed++; $display("FAIL illegal_after: got ill%b pc%0h want ill0 pcc", illegal, pc); end
    alu_cy = 1'b0; alu_zy = 1'b0;
    serve(16'h5A3C, 0, to);
    tests_run++; if ({aluop, rf_rd_addr, imm, imm_sel} !== {5'd2, 5'd19, 8'hAC, 1'b1}) begin tests_failed++; $display("FAIL subi_decode: got op%0d rd%0d imm%0h sel%b want op2 rd19 immac sel1", aluop, rf_rd_addr, imm, imm_sel); end
    tick(); tick();
    tests_run++; if ({flag_c, flag_z} !== 2'b00 || pc !== 8'h0D) begin tests_failed++; $display("FAIL subi_flags: got c%b z%b pc%0h want c0 z0 pcd", flag_c, flag_z, pc); end
    alu_cy = 1'b1; alu_zy = 1'b1;
    serve(16'hE0F1, 0, to); tick();
    tests_run++; if (rf_we !== 1'b1 || rf_rd_addr !== 5'd31) begin tests_failed++; $display("FAIL ldi31: got we%b rd%0d want we1 rd31", rf_we, rf_rd_addr); end
    tick();
    tests_run++; if ({flag_c, flag_z} !== 2'b00 || pc !== 8'h0E) begin tests_failed++; $display("FAIL ldi_noflags: got c%b z%b pc%0h want c0 z0 pce", flag_c, flag_z, pc); end
  endtask

  task automatic test_wrap();
    bit to;
    serve(16'hC0F0, 0, to); tick(); tick();
    tests_run++; if (pc !== 8'hFF) begin tests_failed++; $display("FAIL rjmp_fwd: got pc %0h want ff", pc); end
    serve(16'h0000, 0, to); tick(); tick();
    tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL pc_wrap: got pc %0h want 0", pc); end
  endtask

  task automatic test_break();
    bit to;
    serve(16'h9598, 0, to); tick(); tick();
    tests_run++; if (halt !== 1'b1 || imem_bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL break_halt: got halt%b req%b want halt1 req0", halt, imem_bus.imem_req); end
    start = 1'b1; imem_bus.imem_ack = 1'b1;
    repeat (5) tick();
    start = 1'b0; imem_bus.imem_ack = 1'b0;
    tests_run++; if (halt !== 1'b1 || imem_bus.imem_req !== 1'b0 || pc !== 8'h01) begin tests_failed++; $display("FAIL halt_stuck: got halt%b req%b pc%0h want halt1 req0 pc1", halt, imem_bus.imem_req, pc); end
  endtask

  task automatic test_reset_midfetch();
    bit to;
    reset = 1'b0; tick(); reset = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    serve(16'h0000, 0, to); tick(); tick();
    tests_run++; if (imem_bus.imem_req !== 1'b1 || pc !== 8'h01) begin tests_failed++; $display("FAIL pre_reset: got req%b pc%0h want req1 pc1", imem_bus.imem_req, pc); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if (imem_bus.imem_req !== 1'b0 || pc !== 8'h00 || halt !== 1'b0) begin tests_failed++; $display("FAIL async_reset: got req%b pc%0h halt%b want req0 pc0 halt0", imem_bus.imem_req, pc, halt); end
    @(posedge clk); #1 reset = 1'b1;
    tick();
    tests_run++; if (imem_bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle: got req%b want 0", imem_bus.imem_req); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; alu_cy = 1'b0; alu_zy = 1'b0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    test_reset();
    test_ldi();
    test_add();
    test_cp_branch();
    test_rjmp();
    test_ack_wait();
    test_illegal_imm();
    test_wrap();
    test_break();
    test_reset_midfetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/avr_exec_sequencer.md
Name: avr_exec_sequencer

Overview:
Multi-cycle control FSM for the AVR-subset ALU datapath. It fetches 16-bit instructions from program memory over a req/ack handshake and decodes them into aluop, register-file addresses and immediates. It owns the PC and the C/Z status flags, and sequences one instruction at a time through FETCH, DECODE and EXECUTE. It sits between program memory and the ALU/register-file core.

Parameters:
PC_W, 8, program counter width; instruction word address, wraps modulo 2^PC_W
RST_PC, 0, PC value loaded at reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse; leaves IDLE and begins fetching
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch word address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  16  instruction word
aluop  out  5  ALU operation (avr_seq_pkg codes)
rf_rd_addr  out  5  destination / first source register
rf_rr_addr  out  5  second source register
imm  out  8  immediate operand
imm_sel  out  1  1 = ALU B operand is imm
rf_we  out  1  register-file write strobe, one cycle
alu_cy  in  1  ALU carry out
alu_zy  in  1  ALU zero out
flag_c  out  1  status C; also ALU carry-in for ADC
flag_z  out  1  status Z
pc  out  PC_W  current PC
halt  out  1  BREAK executed
illegal  out  1  one-cycle pulse on an undecodable opcode

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on port reset.
- Reset values: state=IDLE, pc=RST_PC, all other outputs 0, aluop=NOP.
- Asserting reset in any state, including mid-fetch, forces the reset values immediately. imem_req drops without waiting for a clock edge.
- States and transitions:
  - IDLE: waits for start, then goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack. Instruction latched on the cycle where imem_req&&imem_ack; next state DECODE.
  - DECODE: decoder drives aluop, rf_rd_addr, rf_rr_addr, imm, imm_sel. Next state EXECUTE.
  - EXECUTE: ALU result is valid this cycle. Write ops pulse rf_we. Flag-updating ops load flag_c<=alu_cy and flag_z<=alu_zy. PC is updated. Next state is FETCH, or HALT after BREAK.
  - HALT: halt=1 and imem_req=0. Only reset exits HALT.
- Timing: minimum 3 cycles per instruction (ack in the first FETCH cycle). Decode outputs hold from DECODE through EXECUTE.
- start outside IDLE is ignored. imem_ack outside FETCH is ignored.
- Decoded subset (d, r are 5-bit unless noted):
  - ADD 0000_11rd_dddd_rrrr; ADC 0001_11; SUB 0001_10; CP 0001_01; AND 0010_00; EOR 0010_01; OR 0010_10; MOV 0010_11.
  - LDI 1110_KKKK_dddd_KKKK and SUBI 0101_KKKK_dddd_KKKK: register is 16+dddd, imm_sel=1.
  - RJMP 1100_kkkk_kkkk_kkkk: 12-bit signed k.
  - BREQ 1111_00kk_kkkk_k001 and BRNE 1111_01kk_kkkk_k001: 7-bit signed k.
  - NOP 0x0000; BREAK 0x9598.
- rf_we: 1 for ADD, ADC, SUB, SUBI, AND, EOR, OR, MOV, LDI. 0 for CP, branches, RJMP, NOP.
- Flags: updated by ADD, ADC, SUB, SUBI, CP, AND, EOR, OR. Unchanged by MOV, LDI and control ops.
- PC update:
  - Default: pc<=pc+1.
  - RJMP, and a taken BREQ (flag_z=1) or BRNE (flag_z=0): pc<=pc+1+sext(k), truncated to PC_W.
  - Wrap-around is modulo 2^PC_W, e.g. pc=0xFF, +1 gives 0x00.
  - Branch conditions use the flag values held before the EXECUTE update.
- Illegal opcode: executes as NOP and pulses illegal in EXECUTE.

Optional Feature:
AVR_SEQ_STEP_EN
- Defined: adds input step. After each EXECUTE the FSM returns to IDLE, and a step pulse (or start) fetches exactly one instruction.
- Undefined: no step port; after start the FSM runs continuously until BREAK.

Decomposition:
- Package avr_seq_pkg holds:
  - aluop codes: ADD=0, ADC=1, SUB=2, AND=3, OR=4, EOR=5, MOV=6, CP=7, LDI=8, NOP=31.
  - state enum: IDLE, FETCH, DECODE, EXECUTE, HALT.
  - Opcode match/mask constants.
- Sub-module avr_decode: purely combinational instruction to control-field decoder, separately unit-testable.

Test Plan:
1. Reset, start, LDI R16,5 (0xE005), ack same cycle -> EXECUTE has rf_we=1, rf_rd_addr=16, imm=0x05, imm_sel=1, aluop=LDI; pc 0->1.
2. ADD R16,R17 (0x0F01) with alu_cy=1, alu_zy=0 -> rf_we=1, rd=16, rr=17, flag_c=1, flag_z=0.
3. CP R16,R17 (0x1701) with alu_zy=1, then BREQ +3 (0xF019) at pc=5 -> rf_we=0 during CP, flag_z=1, pc=9.
4. RJMP -1 (0xCFFF) at pc=10 -> pc stays 10, rf_we=0; repeats every 3+ cycles.
5. imem_ack withheld 4 cycles -> imem_req=1 and imem_addr stable throughout, no DECODE entry; then 0x0000 gives illegal=0, pc+1.
6. BREAK 0x9598 -> halt=1, imem_req=0 indefinitely. Separately, reset asserted mid-FETCH -> imem_req=0 immediately, pc=RST_PC, state IDLE.
